// File: rtl/data_ram_pkg.sv
// rtl/data_ram_pkg.sv - shared constants and types for the data RAM
//
// Purpose: default geometry, ReadWrite encodings and the clear-sweep FSM
// state type used by data_ram and data_ram_clear_ctrl.
package data_ram_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 10;
  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEPTH              = 1 << DEFAULT_ADDR_WIDTH;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  typedef enum logic {
    CLR_IDLE  = 1'b0,
    CLR_SWEEP = 1'b1
  } clr_state_t;

endpackage

// File: rtl/data_ram_clear_ctrl.sv
// rtl/data_ram_clear_ctrl.sv - post-reset clear sweep counter and Ready generation
//
// Purpose: after reset, walks an address counter over every word, asking the
// RAM to write zero to one word per cycle, and holds Ready low until the last
// word has been cleared. A reset during the sweep restarts it at word 0.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous active-high reset
//   ready     out  1 = sweep finished, RAM accepts accesses
//   clr_we    out  1 = write zero to clr_addr this cycle
//   clr_addr  out  word being cleared
module data_ram_clear_ctrl
  import data_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  ready,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr
);

  localparam logic [ADDR_WIDTH-1:0] ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  clr_state_t            state, state_nx;
  logic [ADDR_WIDTH-1:0] cnt, cnt_nx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLR_SWEEP;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ready    = 1'b1;
    clr_we   = 1'b0;
    case (state)
      CLR_SWEEP: begin
        ready  = 1'b0;
        clr_we = 1'b1;
        cnt_nx = cnt + ONE;
        // all-ones counter is the last word; it is cleared in this cycle
        if (&cnt) begin
          state_nx = CLR_IDLE;
        end
      end
      default: begin
        state_nx = CLR_IDLE;
      end
    endcase
  end

  assign clr_addr = cnt;

endmodule

// File: rtl/data_ram.sv
// rtl/data_ram.sv - single-port synchronous data RAM for the pipeline memory stage
//
// Purpose: 2**ADDR_WIDTH x DATA_WIDTH RAM, one shared address bus, writes
// commit on the clock edge, reads registered with one cycle of latency.
// DataOut only changes on a read or reset (no write-through).
// Optional macro DATA_RAM_CLEAR_EN: reset also zeroes the whole array with a
// one-word-per-cycle sweep, during which Ready is low and accesses are ignored.
//
// Ports:
//   Clk        in   rising-edge clock
//   Reset      in   synchronous active-high reset (DataOut <= 0)
//   Enable     in   access strobe, 0 = no operation
//   ReadWrite  in   1 = write, 0 = read
//   Address    in   word address
//   DataIn     in   write data
//   DataOut    out  registered read data
//   Ready      out  1 = accepting accesses
module data_ram
  import data_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Enable,
  input  logic                  ReadWrite,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [DATA_WIDTH-1:0] DataIn,
  output logic [DATA_WIDTH-1:0] DataOut,
  output logic                  Ready
);

  localparam int MEM_DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic                  ready;
  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;

`ifdef DATA_RAM_CLEAR_EN
  data_ram_clear_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_clear_ctrl (
    .clk      (Clk),
    .reset    (Reset),
    .ready    (ready),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );
`else
  assign ready    = 1'b1;
  assign clr_we   = 1'b0;
  assign clr_addr = '0;
`endif

  logic                  access;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  assign access = Enable && ready;

  // Reset wins over everything, including a write presented in the same cycle.
  assign mem_we    = !Reset && (clr_we || (access && ReadWrite == RW_WRITE));
  assign mem_waddr = clr_we ? clr_addr : Address;
  assign mem_wdata = clr_we ? '0 : DataIn;

  // Array kept free of reset so it maps onto a plain RAM macro.
  always_ff @(posedge Clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      DataOut <= '0;
    end else if (access && ReadWrite == RW_READ) begin
      DataOut <= mem[Address];
    end
  end

  assign Ready = ready;

endmodule

// File: tb/tb_data_ram.sv
// tb/tb_data_ram.sv - self-checking bench for data_ram
module tb_data_ram;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Enable;
  logic       ReadWrite;
  logic [9:0] Address;
  logic [7:0] DataIn;
  logic [7:0] DataOut;
  logic       Ready;

  int errors = 0;
  int checks = 0;

  data_ram dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Enable    (Enable),
    .ReadWrite (ReadWrite),
    .Address   (Address),
    .DataIn    (DataIn),
    .DataOut   (DataOut),
    .Ready     (Ready)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string      name;
    logic       en;
    logic       rw;
    logic [9:0] addr;
    logic [7:0] din;
    logic [7:0] exp;
  } vec_t;

  vec_t vt [15];

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic rw, input logic [9:0] a, input logic [7:0] d);
    Enable    = en;
    ReadWrite = rw;
    Address   = a;
    DataIn    = d;
  endtask

  task automatic wait_ready(input string name, output int n);
    n = 0;
    while (Ready !== 1'b1 && n < 2000) begin
      n++;
      tick();
    end
    if (Ready !== 1'b1) check({name, "_timeout"}, 32'(Ready), 32'd1);
  endtask

  initial begin
    int n;
    logic [7:0] v;

    vt[0]  = '{"wr5_aa",        1'b1, 1'b1, 10'd5,    8'hAA, 8'h0E};
    vt[1]  = '{"rd5",           1'b1, 1'b0, 10'd5,    8'h00, 8'hAA};
    vt[2]  = '{"idle1",         1'b0, 1'b1, 10'd5,    8'h55, 8'hAA};
    vt[3]  = '{"idle2",         1'b0, 1'b1, 10'd5,    8'h55, 8'hAA};
    vt[4]  = '{"idle3",         1'b0, 1'b1, 10'd5,    8'h55, 8'hAA};
    vt[5]  = '{"rd5_again",     1'b1, 1'b0, 10'd5,    8'h00, 8'hAA};
    vt[6]  = '{"wr1023_3c",     1'b1, 1'b1, 10'd1023, 8'h3C, 8'hAA};
    vt[7]  = '{"rd1023_b2b",    1'b1, 1'b0, 10'd1023, 8'h00, 8'h3C};
    vt[8]  = '{"wr2_10",        1'b1, 1'b1, 10'd2,    8'h10, 8'h3C};
    vt[9]  = '{"rd2_10",        1'b1, 1'b0, 10'd2,    8'h00, 8'h10};
    vt[10] = '{"wr2_99_hold",   1'b1, 1'b1, 10'd2,    8'h99, 8'h10};
    vt[11] = '{"idle_hold",     1'b0, 1'b0, 10'd2,    8'h00, 8'h10};
    vt[12] = '{"rd2_99",        1'b1, 1'b0, 10'd2,    8'h00, 8'h99};
    vt[13] = '{"wr7_7f",        1'b1, 1'b1, 10'd7,    8'h7F, 8'h99};
    vt[14] = '{"rd7_7f",        1'b1, 1'b0, 10'd7,    8'h00, 8'h7F};

    Reset = 1'b1;
    drive(1'b0, 1'b0, 10'd0, 8'd0);
    tick();
    tick();
    check("reset_dout", 32'(DataOut), 32'h0);
`ifdef DATA_RAM_CLEAR_EN
    check("reset_ready", 32'(Ready), 32'd0);
`else
    check("reset_ready", 32'(Ready), 32'd1);
`endif
    Reset = 1'b0;
    wait_ready("init_sweep", n);

    // full write sweep with 8-bit wrap, then read sweep
    for (int i = 0; i < 1024; i++) begin
      v = 8'(15 + i);
      drive(1'b1, 1'b1, 10'(i), v);
      tick();
      if (i == 0) check("write_no_dout_change", 32'(DataOut), 32'h0);
    end
    for (int i = 0; i < 1024; i++) begin
      v = 8'(15 + i);
      drive(1'b1, 1'b0, 10'(i), 8'h00);
      tick();
      check($sformatf("sweep_rd_%0d", i), 32'(DataOut), 32'(v));
    end
    check("ready_after_sweep", 32'(Ready), 32'd1);

    // directed vector table
    for (int k = 0; k < 15; k++) begin
      drive(vt[k].en, vt[k].rw, vt[k].addr, vt[k].din);
      tick();
      check(vt[k].name, 32'(DataOut), 32'(vt[k].exp));
    end

`ifdef DATA_RAM_CLEAR_EN
    Reset = 1'b1;
    drive(1'b1, 1'b1, 10'd7, 8'h11);
    tick();
    Reset = 1'b0;
    drive(1'b1, 1'b0, 10'd100, 8'h00);
    check("clr_reset_dout", 32'(DataOut), 32'h0);
    wait_ready("clear_sweep", n);
    check("clr_ready_low_cycles", 32'(n), 32'd1024);
    check("clr_dout_held", 32'(DataOut), 32'h0);
    for (int i = 0; i < 1024; i++) begin
      drive(1'b1, 1'b0, 10'(i), 8'h00);
      tick();
      check($sformatf("clr_rd_%0d", i), 32'(DataOut), 32'h0);
    end
`else
    // reset with a simultaneous write: write dropped, DataOut cleared
    Reset = 1'b1;
    drive(1'b1, 1'b1, 10'd7, 8'h11);
    tick();
    Reset = 1'b0;
    drive(1'b0, 1'b0, 10'd0, 8'h00);
    check("midreset_dout", 32'(DataOut), 32'h0);
    check("midreset_ready", 32'(Ready), 32'd1);
    tick();
    check("post_reset_hold", 32'(DataOut), 32'h0);
    drive(1'b1, 1'b0, 10'd7, 8'h00);
    tick();
    check("rd7_after_reset", 32'(DataOut), 32'h7F);
    drive(1'b1, 1'b0, 10'd1023, 8'h00);
    tick();
    check("rd1023_after_reset", 32'(DataOut), 32'h3C);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
